// File: rtl/klein_key_sched.sv
// ---------------------------------------------------------------------------
// KleinKeySched (module klein_key_sched)
//
// Sequential KLEIN-64/80/96 key scheduler. A key is loaded on start. The
// block then streams round keys sk^1..sk^(NR+1) in forward order, or
// sk^(NR+1)..sk^1 in reverse order for the decryption datapath. It takes one
// schedule step per cycle, and a valid/ready handshake paces the stream.
//
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset
//   start    - load key_in and begin a schedule (only honoured in IDLE)
//   mode     - 00 forward, 01 reverse from master key, 10 reverse from
//              final key, 11 behaves as 00
//   key_in   - sk^1 (modes 00/01) or sk^(NR+1) (mode 10)
//   rk_out   - current round key (registered)
//   rk_idx   - round index of rk_out, 1..NR+1
//   rk_valid - rk_out/rk_idx are valid
//   rk_ready - consumer accepts rk_out this cycle
//   rk_last  - rk_out is the final key of the sequence
//   busy     - scheduler is not idle
//   done     - one-cycle pulse after the final handshake
// ---------------------------------------------------------------------------
module klein_key_sched #(
   parameter int KEY_W = 80,
   parameter int NR    = (KEY_W == 64) ? 12 : (KEY_W == 80) ? 16 : 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [KEY_W-1:0] key_in,
   output logic [KEY_W-1:0] rk_out,
   output logic [4:0]       rk_idx,
   output logic             rk_valid,
   input  logic             rk_ready,
   output logic             rk_last,
   output logic             busy,
   output logic             done
);

   localparam int H = KEY_W / 2;
   localparam logic [4:0] NR_IDX   = 5'(NR);
   localparam logic [4:0] LAST_IDX = 5'(NR + 1);

   // KLEIN only defines 64-, 80- and 96-bit keys.
   if (!(KEY_W == 64 || KEY_W == 80 || KEY_W == 96)) begin : gBadKeyW
      $error("klein_key_sched: KEY_W must be 64, 80 or 96");
   end

   // DONE is a separate state so that the done pulse happens while the block
   // still reports busy. A start in that cycle is therefore not taken.
   typedef enum logic [1:0] {IDLE, PRE, EMIT, DONE} state_e;

   state_e           state_q, state_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic [4:0]       idx_q, idx_d;
   logic             rev_q, rev_d;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'h7;
         4'h1: y = 4'h4;
         4'h2: y = 4'hA;
         4'h3: y = 4'h9;
         4'h4: y = 4'h1;
         4'h5: y = 4'hF;
         4'h6: y = 4'hB;
         4'h7: y = 4'h0;
         4'h8: y = 4'hC;
         4'h9: y = 4'h3;
         4'hA: y = 4'h2;
         4'hB: y = 4'h6;
         4'hC: y = 4'h8;
         4'hD: y = 4'hE;
         4'hE: y = 4'hD;
         default: y = 4'h5;
      endcase
      return y;
   endfunction

   function automatic logic [7:0] sboxByte(input logic [7:0] x);
      return {sbox(x[7:4]), sbox(x[3:0])};
   endfunction

   // Forward step: rotate both halves left by one byte, then apply a Feistel
   // swap. The round counter is mixed into byte 2 of the new upper half, and
   // bytes 1 and 2 of the new lower half pass through the S-box.
   function automatic logic [KEY_W-1:0] fwdStep(input logic [KEY_W-1:0] k,
                                                input logic [4:0]       i);
      logic [H-1:0] a, b, na, nb;
      a  = {k[KEY_W-9:H], k[KEY_W-1:KEY_W-8]};
      b  = {k[H-9:0], k[H-1:H-8]};
      na = b;
      nb = a ^ b;
      na[H-17:H-24] = na[H-17:H-24] ^ {3'b000, i};
      nb[H-9:H-16]  = sboxByte(nb[H-9:H-16]);
      nb[H-17:H-24] = sboxByte(nb[H-17:H-24]);
      return {na, nb};
   endfunction

   // Inverse step: undo fwdStep in reverse order. The S-box is an
   // involution, so the same table removes the substitution.
   function automatic logic [KEY_W-1:0] invStep(input logic [KEY_W-1:0] k,
                                                input logic [4:0]       i);
      logic [H-1:0] a, b, na, nb;
      na = k[KEY_W-1:H];
      nb = k[H-1:0];
      nb[H-9:H-16]  = sboxByte(nb[H-9:H-16]);
      nb[H-17:H-24] = sboxByte(nb[H-17:H-24]);
      na[H-17:H-24] = na[H-17:H-24] ^ {3'b000, i};
      b = na;
      a = nb ^ na;
      return {a[7:0], a[H-1:8], b[7:0], b[H-1:8]};
   endfunction

   // State, key, index and direction registers. Reset clears everything,
   // so an abort mid-schedule leaves no trace and no done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         key_q   <= '0;
         idx_q   <= '0;
         rev_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         idx_q   <= idx_d;
         rev_q   <= rev_d;
      end
   end

   // Next-state logic. PRE runs the forward schedule without presenting it,
   // so that a reverse stream can start from the final key. In EMIT the key
   // only moves on an accepted handshake. Reverse uses round i = idx-1 to
   // recover sk^(idx-1) from sk^idx.
   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      idx_d   = idx_q;
      rev_d   = rev_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               key_d = key_in;
               case (mode)
                  2'b01: begin
                     state_d = PRE;
                     idx_d   = 5'd1;
                     rev_d   = 1'b1;
                  end
                  2'b10: begin
                     state_d = EMIT;
                     idx_d   = LAST_IDX;
                     rev_d   = 1'b1;
                  end
                  default: begin
                     state_d = EMIT;
                     idx_d   = 5'd1;
                     rev_d   = 1'b0;
                  end
               endcase
            end
         end
         PRE: begin
            key_d = fwdStep(key_q, idx_q);
            idx_d = idx_q + 5'd1;
            if (idx_q == NR_IDX) begin
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (rk_ready) begin
               if (rk_last) begin
                  state_d = DONE;
               end else if (rev_q) begin
                  key_d = invStep(key_q, idx_q - 5'd1);
                  idx_d = idx_q - 5'd1;
               end else begin
                  key_d = fwdStep(key_q, idx_q);
                  idx_d = idx_q + 5'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode. The key and index are presented straight from their
   // registers. Because they only change on a handshake, they hold steady
   // while the consumer stalls.
   always_comb begin
      rk_out   = key_q;
      rk_idx   = idx_q;
      rk_valid = (state_q == EMIT);
      rk_last  = (state_q == EMIT) &&
                 (rev_q ? (idx_q == 5'd1) : (idx_q == LAST_IDX));
      busy     = (state_q != IDLE);
      done     = (state_q == DONE);
   end

endmodule
